// File: rtl/del_lfo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : del_lfo                                                      |
// | Description : Triangle-wave sweep generator for the variable delay line.   |
// |               Sweeps the tap offset 'del' between del_min and del_max,     |
// |               stepping once every (rate+1) valid audio samples.            |
// |               Optional macro DEL_LFO_HOLD_EN adds endpoint dwell states    |
// |               (HOLD_HI / HOLD_LO) lasting HOLD_STEPS prescaled steps.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module del_lfo #(
    parameter int BUFR_DEPTH = 512,
    parameter int RATE_WIDTH = 16,
    parameter int HOLD_STEPS = 4,
    localparam int DW = $clog2(BUFR_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  vld_i,
    input  logic [RATE_WIDTH-1:0] rate,
    input  logic [DW-1:0]         del_min,
    input  logic [DW-1:0]         del_max,
    output logic [DW-1:0]         del,
    output logic                  dir_o,
    output logic                  cyc_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_UP      = 3'd1,
`ifdef DEL_LFO_HOLD_EN
        S_HOLD_HI = 3'd3,
        S_HOLD_LO = 3'd4,
`endif
        S_DOWN    = 3'd2
    } state_t;

    state_t                r_state;
    logic [DW-1:0]         r_del;
    logic                  r_dir;
    logic                  r_cyc;
    logic [RATE_WIDTH-1:0] r_div;

    logic w_step;
    logic w_degen;
    logic w_up_top;
    logic w_dn_bot;

`ifdef DEL_LFO_HOLD_EN
    localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [HW-1:0] c_hold_last = HW'(HOLD_STEPS - 1);
    logic [HW-1:0] r_hold;
`else
    // Dwell length only matters when the hold states exist.
    logic w_unused_hold;
    assign w_unused_hold = (HOLD_STEPS != 0);
`endif

    // Prescaler terminal count: >= so a lowered rate takes effect at once.
    assign w_step   = vld_i && (r_div >= rate);
    // Empty or inverted range parks the sweep on del_min.
    assign w_degen  = (del_max <= del_min);
    // Endpoint tests carried out in DW+1 bits so neither wraps nor underflows.
    assign w_up_top = (({1'b0, r_del} + (DW+1)'(1)) >= {1'b0, del_max});
    assign w_dn_bot = ({1'b0, r_del} <= ({1'b0, del_min} + (DW+1)'(1)));

    // Sweep state machine with prescaler and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_del   <= '0;
            r_dir   <= 1'b0;
            r_cyc   <= 1'b0;
            r_div   <= '0;
`ifdef DEL_LFO_HOLD_EN
            r_hold  <= '0;
`endif
        end else begin
            r_cyc <= 1'b0;
            if (!en) begin
                r_state <= S_IDLE;
                r_del   <= del_min;
                r_div   <= '0;
                r_dir   <= 1'b0;
`ifdef DEL_LFO_HOLD_EN
                r_hold  <= '0;
`endif
            end else if (r_state == S_IDLE) begin
                r_state <= S_UP;
                r_del   <= del_min;
                r_div   <= '0;
                r_dir   <= 1'b1;
            end else if (vld_i) begin
                if (w_step) begin
                    r_div <= '0;
                    case (r_state)
                        S_UP: begin
                            if (w_degen) begin
                                r_del <= del_min;
                            end else if (w_up_top) begin
                                r_del <= del_max;
                                r_dir <= 1'b0;
`ifdef DEL_LFO_HOLD_EN
                                r_hold <= '0;
                                if (HOLD_STEPS == 0) r_state <= S_DOWN;
                                else                 r_state <= S_HOLD_HI;
`else
                                r_state <= S_DOWN;
`endif
                            end else begin
                                r_del <= r_del + DW'(1);
                            end
                        end
                        S_DOWN: begin
                            if (w_degen) begin
                                r_del   <= del_min;
                                r_state <= S_UP;
                                r_dir   <= 1'b1;
                            end else if (w_dn_bot) begin
                                r_del <= del_min;
                                r_cyc <= 1'b1;
`ifdef DEL_LFO_HOLD_EN
                                r_hold <= '0;
                                if (HOLD_STEPS == 0) begin
                                    r_state <= S_UP;
                                    r_dir   <= 1'b1;
                                end else begin
                                    r_state <= S_HOLD_LO;
                                end
`else
                                r_state <= S_UP;
                                r_dir   <= 1'b1;
`endif
                            end else begin
                                r_del <= r_del - DW'(1);
                            end
                        end
`ifdef DEL_LFO_HOLD_EN
                        S_HOLD_HI: begin
                            if (r_hold >= c_hold_last) begin
                                r_hold  <= '0;
                                r_state <= S_DOWN;
                            end else begin
                                r_hold <= r_hold + HW'(1);
                            end
                        end
                        S_HOLD_LO: begin
                            if (r_hold >= c_hold_last) begin
                                r_hold  <= '0;
                                r_state <= S_UP;
                                r_dir   <= 1'b1;
                            end else begin
                                r_hold <= r_hold + HW'(1);
                            end
                        end
`endif
                        default: r_state <= S_IDLE;
                    endcase
                end else begin
                    r_div <= r_div + RATE_WIDTH'(1);
                end
            end
        end
    end

    assign del   = r_del;
    assign dir_o = r_dir;
    assign cyc_o = r_cyc;

endmodule
`default_nettype wire

// File: tb/tb_del_lfo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_del_lfo                                                   |
// | Description : Self-checking bench for del_lfo: cycle-level sweep model     |
// |               plus directed vectors with hand-computed expectations.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_del_lfo;
    localparam int DW = 9;
`ifdef DEL_LFO_HOLD_EN
    localparam int HOLD = 2;
`else
    localparam int HOLD = 0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_RISE = 1;
    localparam int M_FALL = 2;
    localparam int M_DWELL_HI = 3;
    localparam int M_DWELL_LO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          vld_i;
    logic [15:0]   rate;
    logic [DW-1:0] del_min;
    logic [DW-1:0] del_max;
    logic [DW-1:0] del;
    logic          dir_o;
    logic          cyc_o;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    del_lfo #(
        .BUFR_DEPTH(512),
        .RATE_WIDTH(16),
        .HOLD_STEPS(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .vld_i   (vld_i),
        .rate    (rate),
        .del_min (del_min),
        .del_max (del_max),
        .del     (del),
        .dir_o   (dir_o),
        .cyc_o   (cyc_o)
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int m_mode  = M_IDLE;
    int m_del   = 0;
    int m_dir   = 0;
    int m_cyc   = 0;
    int m_cnt   = 0;
    int m_dwell = 0;
    bit started = 1'b0;

    task automatic model_step(input int lo, input int hi);
        if ((m_mode == M_RISE || m_mode == M_FALL) && hi <= lo) begin
            m_del  = lo;
            m_mode = M_RISE;
            m_dir  = 1;
        end else begin
            case (m_mode)
                M_RISE: begin
                    if (m_del + 1 >= hi) begin
                        m_del   = hi;
                        m_dir   = 0;
                        m_dwell = HOLD;
                        m_mode  = (HOLD > 0) ? M_DWELL_HI : M_FALL;
                    end else m_del = m_del + 1;
                end
                M_FALL: begin
                    if (m_del <= lo + 1) begin
                        m_del = lo;
                        m_cyc = 1;
                        m_dwell = HOLD;
                        if (HOLD > 0) m_mode = M_DWELL_LO;
                        else begin
                            m_mode = M_RISE;
                            m_dir  = 1;
                        end
                    end else m_del = m_del - 1;
                end
                M_DWELL_HI: begin
                    m_dwell = m_dwell - 1;
                    if (m_dwell == 0) m_mode = M_FALL;
                end
                M_DWELL_LO: begin
                    m_dwell = m_dwell - 1;
                    if (m_dwell == 0) begin
                        m_mode = M_RISE;
                        m_dir  = 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    always @(posedge clk) begin
        int lo, hi;
        lo = int'(del_min);
        hi = int'(del_max);
        m_cyc = 0;
        if (rst) begin
            m_mode = M_IDLE; m_del = 0; m_dir = 0; m_cnt = 0; m_dwell = 0;
        end else if (!en) begin
            m_mode = M_IDLE; m_del = lo; m_dir = 0; m_cnt = 0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_RISE; m_del = lo; m_dir = 1; m_cnt = 0;
        end else if (vld_i) begin
            if (m_cnt < int'(rate)) m_cnt = m_cnt + 1;
            else begin
                m_cnt = 0;
                model_step(lo, hi);
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_del", del, m_del);
            check("model_dir", dir_o, m_dir);
            check("model_cyc", cyc_o, m_cyc);
        end
    end

    // ---------------- directed stimulus ----------------
`ifdef DEL_LFO_HOLD_EN
    localparam int S1N = 11;
    int s1_del[S1N] = '{11, 12, 13, 13, 13, 12, 11, 10, 10, 10, 11};
    int s1_cyc[S1N] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    int s6_del[9]   = '{11, 12, 12, 12, 11, 10, 10, 10, 11};
    int s6_cyc[9]   = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
`else
    localparam int S1N = 7;
    int s1_del[S1N] = '{11, 12, 13, 12, 11, 10, 11};
    int s1_cyc[S1N] = '{0, 0, 0, 0, 0, 1, 0};
`endif

    task automatic wait_del(input int v, input string nm);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (int'(del) == v) break;
        end
        check(nm, del, v);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; vld_i = 1'b1; rate = 16'd0;
        del_min = 9'd10; del_max = 9'd13;
        @(negedge clk); @(negedge clk);
        check("reset_del", del, 0);
        check("reset_dir", dir_o, 0);
        check("reset_cyc", cyc_o, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_del", del, 10);
        check("idle_dir", dir_o, 0);
        en = 1'b1;
        @(negedge clk);
        check("up_entry_dir", dir_o, 1);
        check("up_entry_del", del, 10);
        for (int i = 0; i < S1N; i++) begin
            @(negedge clk);
            check("sweep_del", del, s1_del[i]);
            check("sweep_cyc", cyc_o, s1_cyc[i]);
        end
        en = 1'b0;
        @(negedge clk);
        check("en_off_del", del, 10);

        // Prescaled sweep: rate 3 with a strobe every 4th clock.
        del_min = 9'd0; del_max = 9'd2; rate = 16'd3; vld_i = 1'b0; en = 1'b1;
        for (int k = 1; k <= 66; k++) begin
            @(negedge clk);
`ifndef DEL_LFO_HOLD_EN
            if (k == 16) check("pre_k16", del, 0);
            if (k == 17) check("pre_k17", del, 1);
            if (k == 33) check("pre_k33", del, 2);
            if (k == 49) check("pre_k49", del, 1);
            if (k == 65) begin
                check("pre_k65", del, 0);
                check("pre_k65_cyc", cyc_o, 1);
            end
`endif
            vld_i = ((k % 4) == 0);
        end
        en = 1'b0; vld_i = 1'b1; rate = 16'd0;
        @(negedge clk);

        // Upper bound lowered below del mid-sweep.
        del_min = 9'd0; del_max = 9'd20; en = 1'b1;
        wait_del(12, "mid_reach12");
        del_max = 9'd5;
        @(negedge clk);
        check("clamp_del", del, 5);
        check("clamp_dir", dir_o, 0);
`ifndef DEL_LFO_HOLD_EN
        for (int v = 4; v >= 0; v--) begin
            @(negedge clk);
            check("clamp_fall", del, v);
        end
        check("clamp_cyc", cyc_o, 1);
`endif
        en = 1'b0;
        @(negedge clk);
        check("clamp_off", del, 0);

        // Enable dropped mid-sweep.
        del_min = 9'd3; del_max = 9'd20; en = 1'b1;
        wait_del(12, "drop_reach12");
        en = 1'b0;
        @(negedge clk);
        check("drop_del", del, 3);
        check("drop_dir", dir_o, 0);
        check("drop_cyc", cyc_o, 0);

        // Degenerate range min == max.
        del_min = 9'd20; del_max = 9'd20; en = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("degen_del", del, 20);
            check("degen_cyc", cyc_o, 0);
        end
        en = 1'b0;
        @(negedge clk);

        // Reset asserted mid-sweep.
        del_min = 9'd0; del_max = 9'd30; en = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_del", del, 0);
        check("rst_mid_dir", dir_o, 0);
        rst = 1'b0; en = 1'b0;
        @(negedge clk);

`ifdef DEL_LFO_HOLD_EN
        // Endpoint dwell of two steps.
        del_min = 9'd10; del_max = 9'd12;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check("hold_entry", del, 10);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("hold_del", del, s6_del[i]);
            check("hold_cyc", cyc_o, s6_cyc[i]);
        end
        en = 1'b0;
`endif
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
